// File: rtl/sdram_protocol_monitor.sv
// sdram_protocol_monitor: passive SDRAM command-bus protocol checker.
// Checks init sequence, bank open/close, tRCD/tRAS/tRP and CAS-latency read data.
//
// Ports:
//   sdram_clk, sdram_resetn   clock (posedge) and async active-low reset
//   mon_en                    0 suppresses all flag/pulse/count updates
//   sdr_cs_n/ras_n/cas_n/we_n command pins, sdr_ba bank, sdr_a10 precharge-all
//   cfg_sdr_mode_reg          mode register, CAS latency in [6:4]
//   sdr_dq_valid              read data present on DQ this cycle
//   err_clr                   synchronous clear of err_flags / err_count
//   init_done                 init sequence finished (sticky until reset)
//   err_flags                 sticky [0]INIT [1]BANK [2]TRCD [3]TRAS [4]TRP [5]CL
//   err_pulse                 one-cycle pulse after any new error
//   err_count                 saturating count of cycles with a new error
module sdram_protocol_monitor #(
    parameter int NUM_BANKS    = 4,
    parameter int BA_W         = 2,
    parameter int INIT_NOP_CYC = 500,
    parameter int INIT_AREF    = 2,
    parameter int INIT_TO      = 100,
    parameter int T_RCD        = 3,
    parameter int T_RAS        = 6,
    parameter int T_RP         = 3,
    parameter int CAS_MAX      = 3,
    parameter int CNT_W        = 8
) (
    input  logic             sdram_clk,
    input  logic             sdram_resetn,
    input  logic             mon_en,
    input  logic             sdr_cs_n,
    input  logic             sdr_ras_n,
    input  logic             sdr_cas_n,
    input  logic             sdr_we_n,
    input  logic [BA_W-1:0]  sdr_ba,
    input  logic             sdr_a10,
    input  logic [12:0]      cfg_sdr_mode_reg,
    input  logic             sdr_dq_valid,
    input  logic             err_clr,
    output logic             init_done,
    output logic [5:0]       err_flags,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
);

    localparam int T_M1  = (T_RAS > T_RCD) ? T_RAS : T_RCD;
    localparam int T_MAX = (T_M1 > T_RP) ? T_M1 : T_RP;
    localparam int TW    = $clog2(T_MAX + 1);
    localparam int NW    = $clog2(INIT_NOP_CYC + 1);
    localparam int WW    = $clog2(INIT_TO + 1);
    localparam int AW    = $clog2(INIT_AREF + 1);

    localparam logic [TW-1:0] SAT   = TW'(T_MAX);
    localparam logic [TW-1:0] RCD_L = TW'(T_RCD);
    localparam logic [TW-1:0] RAS_L = TW'(T_RAS);
    localparam logic [TW-1:0] RP_L  = TW'(T_RP);

    typedef enum logic [2:0] {
        S_NOP_WAIT,
        S_WAIT_PRE,
        S_WAIT_AREF,
        S_WAIT_MRS,
        S_DONE
    } state_t;

    // ---------------- command decode ----------------
    logic [2:0] cmd;
    logic       is_nop, is_act, is_rd, is_wr, is_pre, is_aref, is_mrs;

    // deselect behaves exactly like NOP
    assign cmd     = sdr_cs_n ? 3'b111 : {sdr_ras_n, sdr_cas_n, sdr_we_n};
    assign is_nop  = (cmd == 3'b111);
    assign is_act  = (cmd == 3'b011);
    assign is_rd   = (cmd == 3'b101);
    assign is_wr   = (cmd == 3'b100);
    assign is_pre  = (cmd == 3'b010);
    assign is_aref = (cmd == 3'b001);
    assign is_mrs  = (cmd == 3'b000);

    // ---------------- init FSM ----------------
    state_t        st_q, st_d;
    logic [NW-1:0] nop_cnt_q, nop_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [AW-1:0] aref_cnt_q, aref_cnt_d;
    logic          init_done_q, init_done_d;
    logic          wait_to, e_init, in_done;

    assign wait_to = (wait_cnt_q == WW'(INIT_TO - 1));
    assign in_done = (st_q == S_DONE);

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            st_q        <= S_NOP_WAIT;
            nop_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            aref_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            nop_cnt_q   <= nop_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            aref_cnt_q  <= aref_cnt_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        st_d       = st_q;
        nop_cnt_d  = nop_cnt_q;
        wait_cnt_d = wait_cnt_q;
        aref_cnt_d = aref_cnt_q;
        if (e_init) begin
            // an init violation abandons the sequence for good
            st_d = S_DONE;
        end else begin
            unique case (st_q)
                S_NOP_WAIT: begin
                    if (nop_cnt_q == NW'(INIT_NOP_CYC - 1)) begin
                        st_d       = S_WAIT_PRE;
                        wait_cnt_d = '0;
                    end else begin
                        nop_cnt_d = nop_cnt_q + NW'(1);
                    end
                end
                S_WAIT_PRE: begin
                    if (is_pre) begin
                        st_d       = S_WAIT_AREF;
                        wait_cnt_d = '0;
                        aref_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WW'(1);
                    end
                end
                S_WAIT_AREF: begin
                    if (is_aref) begin
                        // timeout window restarts for each refresh
                        wait_cnt_d = '0;
                        if (aref_cnt_q == AW'(INIT_AREF - 1)) begin
                            st_d = S_WAIT_MRS;
                        end else begin
                            aref_cnt_d = aref_cnt_q + AW'(1);
                        end
                    end else begin
                        wait_cnt_d = wait_cnt_q + WW'(1);
                    end
                end
                S_WAIT_MRS: begin
                    if (is_mrs) begin
                        st_d = S_DONE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        e_init = 1'b0;
        unique case (st_q)
            S_NOP_WAIT:  e_init = !is_nop;
            S_WAIT_PRE:  e_init = is_nop ? wait_to : !is_pre;
            S_WAIT_AREF: e_init = is_nop ? wait_to : !is_aref;
            S_WAIT_MRS:  e_init = is_nop ? wait_to : !is_mrs;
            default:     e_init = 1'b0;
        endcase
    end

    assign init_done_d = init_done_q | (st_d == S_DONE);

    // ---------------- bank state and timing ----------------
    // sa/sp hold cycles since last ACT/PRE per bank, saturating at T_MAX
    logic [NUM_BANKS-1:0]         open_q, open_d;
    logic [NUM_BANKS-1:0][TW-1:0] sa_q, sa_d;
    logic [NUM_BANKS-1:0][TW-1:0] sp_q, sp_d;
    logic                         e_bank, e_trcd, e_tras, e_trp;

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            open_q <= '0;
            sa_q   <= {NUM_BANKS{SAT}};
            sp_q   <= {NUM_BANKS{SAT}};
        end else begin
            open_q <= open_d;
            sa_q   <= sa_d;
            sp_q   <= sp_d;
        end
    end

    always_comb begin
        open_d = open_q;
        e_bank = 1'b0;
        e_trcd = 1'b0;
        e_tras = 1'b0;
        e_trp  = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            sa_d[b] = (sa_q[b] == SAT) ? SAT : sa_q[b] + TW'(1);
            sp_d[b] = (sp_q[b] == SAT) ? SAT : sp_q[b] + TW'(1);
        end
        if (in_done) begin
            if (is_act) begin
                if (open_q[sdr_ba]) e_bank = 1'b1;
                if (sp_q[sdr_ba] < RP_L) e_trp = 1'b1;
                open_d[sdr_ba] = 1'b1;
                sa_d[sdr_ba]   = TW'(1);
            end
            if (is_rd || is_wr) begin
                if (!open_q[sdr_ba]) begin
                    e_bank = 1'b1;
                end else if (sa_q[sdr_ba] < RCD_L) begin
                    e_trcd = 1'b1;
                end
            end
            if (is_pre) begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    if (sdr_a10 || (BA_W'(b) == sdr_ba)) begin
                        // closing an already-closed bank is legal
                        if (open_q[b] && (sa_q[b] < RAS_L)) e_tras = 1'b1;
                        open_d[b] = 1'b0;
                        sp_d[b]   = TW'(1);
                    end
                end
            end
            if (is_aref && (|open_q)) e_bank = 1'b1;
        end
    end

    // ---------------- CAS latency ----------------
    // due_q[i] set: read data expected i cycles from now
    logic [2:0]         cl;
    logic               cl_ok, rd_chk, e_cl;
    logic [CAS_MAX-1:0] due_q, due_d;
    logic               unused_mode;

    assign cl          = cfg_sdr_mode_reg[6:4];
    assign unused_mode = ^{cfg_sdr_mode_reg[12:7], cfg_sdr_mode_reg[3:0]};
    assign cl_ok       = ((cl == 3'd2) || (cl == 3'd3)) && (int'(cl) <= CAS_MAX);
    assign rd_chk      = in_done && is_rd;

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            due_q <= '0;
        end else begin
            due_q <= due_d;
        end
    end

    always_comb begin
        due_d = due_q >> 1;
        for (int i = 0; i < CAS_MAX; i++) begin
            if (rd_chk && cl_ok && (int'(cl) == i + 1)) due_d[i] = 1'b1;
        end
    end

    assign e_cl = (rd_chk && !cl_ok) || (due_q[0] && !sdr_dq_valid);

    // ---------------- reporting ----------------
    logic [5:0]       err_new;
    logic [5:0]       flags_q, flags_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    assign err_new = {e_cl, e_trp, e_tras, e_trcd, e_bank, e_init};

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            flags_q <= '0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    // clear first, so an error in the clearing cycle survives
    always_comb begin
        flags_d = err_clr ? '0 : flags_q;
        cnt_d   = err_clr ? '0 : cnt_q;
        pulse_d = 1'b0;
        if (mon_en && (|err_new)) begin
            flags_d = flags_d | err_new;
            pulse_d = 1'b1;
            if (cnt_d != '1) cnt_d = cnt_d + CNT_W'(1);
        end
    end

    assign init_done = init_done_q;
    assign err_flags = flags_q;
    assign err_pulse = pulse_q;
    assign err_count = cnt_q;

endmodule
